// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared store size codes, FSM encoding and address helper
package mem_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_BAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FAULT = 2'b10
    } store_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_lane_pack.sv
// rtl/store_lane_pack.sv - combinational lane replication, byte enables and alignment check
module store_lane_pack
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        fault
);

    always_comb begin
        wdata = '0;
        be    = '0;
        fault = 1'b0;
        unique case (size)
            SIZE_B: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr;
            end
            SIZE_H: begin
                wdata = {2{data[15:0]}};
                be    = addr[1] ? 4'b1100 : 4'b0011;
                fault = addr[0];
            end
            SIZE_W: begin
                wdata = data;
                be    = 4'b1111;
                fault = (addr != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_data_packer.sv
// rtl/store_data_packer.sv - MEM-stage store formatter running one req/ack write to data memory
module store_data_packer
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam int             CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);

    store_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic          st_done_q, st_done_d;
    logic          misalign_q, misalign_d;
    logic          bus_err_q, bus_err_d;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic        lane_fault;
    logic        accept;
    logic        cnt_last;

    store_lane_pack u_lane_pack (
        .size  (st_size),
        .addr  (st_addr[1:0]),
        .data  (st_data),
        .wdata (lane_wdata),
        .be    (lane_be),
        .fault (lane_fault)
    );

    assign accept   = st_valid && (state_q == ST_IDLE);
    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (st_valid) state_d = lane_fault ? ST_FAULT : ST_BUSY;
            ST_BUSY:  if (mem_ack || cnt_last) state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Ack is tested before the timeout so a late ack on the last cycle still completes the write.
    always_comb begin
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        st_done_d   = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        if (accept) begin
            if (lane_fault) begin
                misalign_d = 1'b1;
            end else begin
                mem_req_d   = 1'b1;
                mem_addr_d  = word_align(st_addr);
                mem_wdata_d = lane_wdata;
                mem_be_d    = lane_be;
                cnt_d       = '0;
            end
        end
        if (state_q == ST_BUSY) begin
            if (mem_ack) begin
                mem_req_d = 1'b0;
                st_done_d = 1'b1;
            end else if (cnt_last) begin
                mem_req_d = 1'b0;
                bus_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            st_done_q   <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            st_done_q   <= st_done_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign st_ready     = (state_q == ST_IDLE);
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign st_done      = st_done_q;
    assign misalign_exc = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_store_data_packer.sv
// tb/tb_store_data_packer.sv - scoreboard bench for store_data_packer
module tb_store_data_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic [1:0]  st_size = 2'b00;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        st_done;
    logic        misalign_exc;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    logic [67:0] exp_req_q[$];
    logic [2:0]  exp_evt_q[$];
    logic        prev_req = 1'b0;

    localparam logic [2:0] EV_DONE = 3'b001;
    localparam logic [2:0] EV_MIS  = 3'b010;
    localparam logic [2:0] EV_ERR  = 3'b100;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [2:0]  e_evt;
    } vec_t;

    vec_t vecs[10];

    store_data_packer #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_size      (st_size),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_ready     (st_ready),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .st_done      (st_done),
        .misalign_exc (misalign_exc),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_req <= 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (exp_req_q.size() == 0) chk("unexpected_req", 1, 0);
                else chk("req_fields", {mem_addr, mem_wdata, mem_be}, exp_req_q.pop_front());
            end
            prev_req <= mem_req;
            if (st_done || misalign_exc || bus_err) begin
                if (exp_evt_q.size() == 0) chk("unexpected_evt", {bus_err, misalign_exc, st_done}, 0);
                else chk("evt", {bus_err, misalign_exc, st_done}, exp_evt_q.pop_front());
            end
        end
    end

    // Called just after a rising edge with the DUT in IDLE.
    task automatic run_vec(input int i);
        vec_t v;
        int   nwait;
        v = vecs[i];
        st_size  = v.size;
        st_addr  = v.addr;
        st_data  = v.data;
        st_valid = 1'b1;
        if (v.e_evt != EV_MIS) exp_req_q.push_back({v.e_addr, v.e_wdata, v.e_be});
        exp_evt_q.push_back(v.e_evt);
        @(negedge clk);
        chk("ready_before", st_ready, 1);
        @(posedge clk); #1;
        st_valid = 1'b0;
        st_addr  = $urandom;
        st_data  = $urandom;
        if (v.e_evt == EV_MIS) begin
            @(negedge clk);
            chk("fault_ready", st_ready, 0);
            chk("fault_req", mem_req, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("fault_ready_after", st_ready, 1);
            chk("fault_req_after", mem_req, 0);
        end else begin
            nwait = (v.waits < 0) ? 16 : v.waits;
            for (int k = 0; k < nwait; k++) begin
                @(negedge clk);
                chk("busy_req", mem_req, 1);
                chk("busy_ready", st_ready, 0);
                chk("busy_hold", {mem_addr, mem_wdata, mem_be}, {v.e_addr, v.e_wdata, v.e_be});
                @(posedge clk); #1;
            end
            if (v.waits >= 0) begin
                mem_ack = 1'b1;
                @(negedge clk);
                chk("ack_req", mem_req, 1);
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
            @(negedge clk);
            chk("end_req", mem_req, 0);
            chk("end_ready", st_ready, 1);
            chk("end_done", st_done, (v.waits >= 0));
            chk("end_err", bus_err, (v.waits < 0));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 32'h0000_0103, 32'h1122_3344, 0,  32'h0000_0100, 32'h4444_4444, 4'b1000, EV_DONE};
        vecs[1] = '{2'b01, 32'h0000_0202, 32'h0000_BEEF, 3,  32'h0000_0200, 32'hBEEF_BEEF, 4'b1100, EV_DONE};
        vecs[2] = '{2'b10, 32'h0000_0301, 32'h1234_5678, 0,  32'h0,         32'h0,         4'b0000, EV_MIS};
        vecs[3] = '{2'b11, 32'h0000_0500, 32'h1234_5678, 0,  32'h0,         32'h0,         4'b0000, EV_MIS};
        vecs[4] = '{2'b10, 32'h0000_0400, 32'hCAFE_F00D, -1, 32'h0000_0400, 32'hCAFE_F00D, 4'b1111, EV_ERR};
        vecs[5] = '{2'b10, 32'h0000_0404, 32'h1234_5678, 15, 32'h0000_0404, 32'h1234_5678, 4'b1111, EV_DONE};
        vecs[6] = '{2'b00, 32'h0000_0001, 32'h0000_00A5, 1,  32'h0000_0000, 32'hA5A5_A5A5, 4'b0010, EV_DONE};
        vecs[7] = '{2'b01, 32'h0000_0010, 32'hFFFF_1234, 0,  32'h0000_0010, 32'h1234_1234, 4'b0011, EV_DONE};
        vecs[8] = '{2'b01, 32'h0000_0011, 32'hFFFF_1234, 0,  32'h0,         32'h0,         4'b0000, EV_MIS};
        vecs[9] = '{2'b00, 32'h0000_0002, 32'h0000_007F, 2,  32'h0000_0000, 32'h7F7F_7F7F, 4'b0100, EV_DONE};

        #2;
        chk("rst_ready", st_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_data", {mem_addr, mem_wdata, mem_be}, 0);
        chk("rst_pulses", {bus_err, misalign_exc, st_done}, 0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(i);

        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_ready", st_ready, 1);

        // Back-to-back words, zero-wait ack, second held pending through BUSY
        @(posedge clk); #1;
        st_size = 2'b10; st_addr = 32'h600; st_data = 32'hAAAA_5555; st_valid = 1'b1;
        exp_req_q.push_back({32'h600, 32'hAAAA_5555, 4'b1111});
        exp_evt_q.push_back(EV_DONE);
        @(posedge clk); #1;
        st_addr = 32'h604; st_data = 32'h0102_0304; mem_ack = 1'b1;
        exp_req_q.push_back({32'h604, 32'h0102_0304, 4'b1111});
        exp_evt_q.push_back(EV_DONE);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_done", st_done, 1);
        chk("b2b_ready", st_ready, 1);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_req", {mem_req, mem_addr}, {1'b1, 32'h604});
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("b2b_second_done", st_done, 1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a write
        st_size = 2'b10; st_addr = 32'h700; st_data = 32'h0BAD_F00D; st_valid = 1'b1;
        exp_req_q.push_back({32'h700, 32'h0BAD_F00D, 4'b1111});
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_ready", st_ready, 1);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("post_rst_req", mem_req, 0);

        chk("req_queue_empty", exp_req_q.size(), 0);
        chk("evt_queue_empty", exp_evt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
